// File: rtl/decoder_pkg.sv
// Decoder-level constants shared by peripherals hanging off the CSR decoder.
package decoder_pkg;

    // Default UART bit period in system clocks.
    localparam int unsigned UartCmpVal = 32'd868;

endpackage

// File: rtl/uart_pkg.sv
// Types and helpers for the word-fed UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } uart_tx_state_e;

    localparam int unsigned PeriodW = 32;

    // Bit period minus one. A shift that overflows to zero is read as a
    // one-clock period so the timer never stalls.
    function automatic logic [PeriodW-1:0] period_m1(input logic [PeriodW-1:0] base,
                                                     input logic [3:0]         shamt);
        logic [PeriodW-1:0] p;
        p = base << shamt;
        if (p == '0) begin
            p = PeriodW'(1);
        end
        return p - PeriodW'(1);
    endfunction

endpackage

// File: rtl/uart_tx_word_baud_tick.sv
// Bit-period down-counter: ticks when it reaches zero and reloads itself,
// so consecutive bits are exactly one period apart.
module uart_baud_tick #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             restart_i,
    input  logic [Width-1:0] restart_val_i,
    input  logic [Width-1:0] reload_val_i,
    output logic             tick_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Restart wins over the automatic reload at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = restart_val_i;
        end else if (cnt_q == '0) begin
            cnt_d = reload_val_i;
        end else begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_word.sv
// Word-fed UART transmitter: serialises bytes 0..count of a word, LSB byte
// and LSB bit first, with optional parity, 1/2 stop bits and a trailing gap.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, ready for a new word
// ST_START  | start bit (0)
// ST_DATA   | DataBits data bits from the current byte lane
// ST_PARITY | parity bit (even or odd)
// ST_STOP   | one or two stop bits (1)
// ST_GAP    | GapBits idle bit-times after the last byte
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int unsigned WordWidth = 32,
    parameter int unsigned DataBits  = 8,
    parameter int unsigned BaudCmp   = decoder_pkg::UartCmpVal,
    parameter int unsigned GapBits   = 0,
    localparam int unsigned Lanes    = WordWidth / 8,
    localparam int unsigned CountW   = (Lanes > 1) ? $clog2(Lanes) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [WordWidth-1:0] data_i,
    input  logic [CountW-1:0]    count_i,
    input  parity_e              parity_i,
    input  logic                 stop2_i,
    input  logic [3:0]           prescaler_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // Wide enough for data bit index (up to 7) and the gap bit index.
    localparam int unsigned BitW = ($clog2(GapBits + 1) > 3) ? $clog2(GapBits + 1) : 3;

    uart_tx_state_e       state_q, state_d;
    logic [WordWidth-1:0] data_q, data_d;
    logic [CountW-1:0]    count_q, count_d;
    parity_e              parity_q, parity_d;
    logic                 stop2_q, stop2_d;
    logic [PeriodW-1:0]   pm1_q, pm1_d;
    logic [CountW-1:0]    byte_q, byte_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 ready_q, ready_d;

    logic                 tick;
    logic                 accept;
    logic                 done_d;
    logic [PeriodW-1:0]   pm1_in;
    logic [CountW-1:0]    count_in;
    logic [7:0]           lane;

    assign accept = valid_i && ready_q;
    assign pm1_in = period_m1(PeriodW'(BaudCmp), prescaler_i);

    // Never let the byte counter run past the last lane of the word.
    assign count_in = (count_i > CountW'(Lanes - 1)) ? CountW'(Lanes - 1) : count_i;

    // Byte lane currently addressed by the byte counter.
    always_comb begin
        lane = '0;
        for (int unsigned k = 0; k < Lanes; k++) begin
            if (byte_q == CountW'(k)) begin
                lane = data_q[8*k +: 8];
            end
        end
    end

    uart_baud_tick #(
        .Width(PeriodW)
    ) u_baud_tick (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .restart_i    (accept),
        .restart_val_i(pm1_in),
        .reload_val_i (pm1_q),
        .tick_o       (tick)
    );

    // Next-state logic: all transitions happen on bit-timer expiry except accept.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        count_d  = count_q;
        parity_d = parity_q;
        stop2_d  = stop2_q;
        pm1_d    = pm1_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d   = data_i;
                    count_d  = count_in;
                    parity_d = parity_i;
                    stop2_d  = stop2_i;
                    pm1_d    = pm1_in;
                    byte_d   = '0;
                    bit_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    shift_d = lane;
                    par_d   = 1'b0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BitW'(DataBits - 1)) begin
                        bit_d   = '0;
                        state_d = (parity_q == PAR_EVEN || parity_q == PAR_ODD) ? ST_PARITY
                                                                               : ST_STOP;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop2_q && bit_q == '0) begin
                        bit_d = BitW'(1);
                    end else begin
                        bit_d = '0;
                        if (byte_q != count_q) begin
                            byte_d  = byte_q + CountW'(1);
                            state_d = ST_START;
                        end else if (GapBits > 0) begin
                            state_d = ST_GAP;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (bit_q == BitW'(GapBits - 1)) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is registered from the next state, so it is high exactly in IDLE
    // once the first edge after reset has passed.
    assign ready_d = (state_d == ST_IDLE);

    // State, datapath and configuration registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            count_q  <= '0;
            parity_q <= PAR_NONE;
            stop2_q  <= 1'b0;
            pm1_q    <= '0;
            byte_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            count_q  <= count_d;
            parity_q <= parity_d;
            stop2_q  <= stop2_d;
            pm1_q    <= pm1_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            ready_q  <= ready_d;
        end
    end

    // Line level decoded from state; reset forces IDLE and hence a high line at once.
    always_comb begin
        tx_o = 1'b1;
        unique case (state_q)
            ST_START:  tx_o = 1'b0;
            ST_DATA:   tx_o = shift_q[0];
            ST_PARITY: tx_o = par_q ^ (parity_q == PAR_ODD);
            default:   tx_o = 1'b1;
        endcase
    end

    assign ready_o = ready_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_d;

endmodule
